unidade_controle_desafio: RTL and testbench

Moore FSM that sequences the memory-game datapath (address counter, round counter, play register, timeout counter, sync ROM, comparators). Each round N (0..15) the player must replay ROM words 0..N; the round ends when the last address of the round is matched, and the game ends on a mismatch, a timeout or completion of round 15. It sits beside the datapath in the game top level and drives all of its control strobes from the datapath status flags.

---
 rtl/unidade_controle_desafio.sv | 136 +++++++++++++
 tb/tb_unidade_controle_desafio.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_desafio.sv
// Control FSM for the memory game: sequences rounds of plays against the ROM
// and reports win, wrong play or timeout. All outputs are decoded from state only.
module unidade_controle_desafio #(
    parameter bit USE_TIMEOUT = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       jogadaIgualMemoria,
    input  logic       enderecoIgualSequencia,
    input  logic       fimS,
    input  logic       timeout,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraS,
    output logic       contaS,
    output logic       zeraR,
    output logic       registraR,
    output logic       estado_espera,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       fim_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        ESTADO_ACERTOU = 4'hA,
        ESTADO_TIMEOUT = 4'hD,
        ESTADO_ERROU   = 4'hE
    } state_t;

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= INICIAL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INICIAL:        if (iniciar) state_next = PREPARACAO;
            PREPARACAO:     state_next = INICIO_RODADA;
            INICIO_RODADA:  state_next = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // a timeout arriving together with a play still ends the game
                if (USE_TIMEOUT && timeout) state_next = ESTADO_TIMEOUT;
                else if (jogada)            state_next = REGISTRA;
            end
            REGISTRA:       state_next = COMPARACAO;
            COMPARACAO: begin
                if (!jogadaIgualMemoria)          state_next = ESTADO_ERROU;
                else if (!enderecoIgualSequencia) state_next = PROXIMA_JOGADA;
                else if (fimS)                    state_next = ESTADO_ACERTOU;
                else                              state_next = PROXIMA_RODADA;
            end
            PROXIMA_JOGADA: state_next = ESPERA_JOGADA;
            PROXIMA_RODADA: state_next = INICIO_RODADA;
            ESTADO_ACERTOU,
            ESTADO_TIMEOUT,
            ESTADO_ERROU:   if (iniciar) state_next = PREPARACAO;
            default:        state_next = INICIAL;
        endcase
    end

    always_comb begin
        zeraE         = 1'b0;
        contaE        = 1'b0;
        zeraS         = 1'b0;
        contaS        = 1'b0;
        zeraR         = 1'b0;
        registraR     = 1'b0;
        estado_espera = 1'b0;
        pronto        = 1'b0;
        acertou       = 1'b0;
        errou         = 1'b0;
        fim_timeout   = 1'b0;
        db_estado     = 4'h0;
        case (state_reg)
            INICIAL:        db_estado = 4'h0;
            PREPARACAO: begin
                zeraE = 1'b1; zeraS = 1'b1; zeraR = 1'b1;
                db_estado = 4'h1;
            end
            INICIO_RODADA: begin
                zeraE = 1'b1;
                db_estado = 4'h2;
            end
            ESPERA_JOGADA: begin
                estado_espera = 1'b1;
                db_estado = 4'h3;
            end
            REGISTRA: begin
                registraR = 1'b1;
                db_estado = 4'h4;
            end
            COMPARACAO:     db_estado = 4'h5;
            PROXIMA_JOGADA: begin
                contaE = 1'b1;
                db_estado = 4'h6;
            end
            PROXIMA_RODADA: begin
                contaS = 1'b1;
                db_estado = 4'h7;
            end
            ESTADO_ACERTOU: begin
                pronto = 1'b1; acertou = 1'b1;
                db_estado = 4'hA;
            end
            ESTADO_TIMEOUT: begin
                pronto = 1'b1; fim_timeout = 1'b1;
                db_estado = 4'hD;
            end
            ESTADO_ERROU: begin
                pronto = 1'b1; errou = 1'b1;
                db_estado = 4'hE;
            end
            default:        db_estado = 4'h0;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_desafio.sv
// Bench for the memory-game control FSM: a table-driven game model checked
// every cycle against two instances (timeout honoured / ignored), plus literal checks.
module tb_unidade_controle_desafio;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic iniciar = 1'b0;
    logic jogada = 1'b0;
    logic timeout = 1'b0;
    logic s_eq = 1'b0, s_eis = 1'b0, s_fim = 1'b0;
    logic win_mode = 1'b0;
    logic jogadaIgualMemoria, enderecoIgualSequencia, fimS;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    // datapath stand-in used for the full-game run
    logic [3:0] dp_addr = 4'd0;
    logic [3:0] dp_round = 4'd0;
    assign jogadaIgualMemoria     = win_mode ? 1'b1 : s_eq;
    assign enderecoIgualSequencia = win_mode ? (dp_addr == dp_round) : s_eis;
    assign fimS                   = win_mode ? (dp_round == 4'd15) : s_fim;

    logic [10:0] o1, o2;
    logic [3:0]  db1, db2;
    logic zeraE1, contaE1, zeraS1, contaS1, zeraR1, registraR1, espera1, pronto1, acertou1, errou1, fim_to1;
    logic zeraE2, contaE2, zeraS2, contaS2, zeraR2, registraR2, espera2, pronto2, acertou2, errou2, fim_to2;

    unidade_controle_desafio #(.USE_TIMEOUT(1'b1)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .jogadaIgualMemoria(jogadaIgualMemoria), .enderecoIgualSequencia(enderecoIgualSequencia),
        .fimS(fimS), .timeout(timeout),
        .zeraE(zeraE1), .contaE(contaE1), .zeraS(zeraS1), .contaS(contaS1),
        .zeraR(zeraR1), .registraR(registraR1), .estado_espera(espera1),
        .pronto(pronto1), .acertou(acertou1), .errou(errou1), .fim_timeout(fim_to1),
        .db_estado(db1)
    );

    unidade_controle_desafio #(.USE_TIMEOUT(1'b0)) dut_nt (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .jogadaIgualMemoria(jogadaIgualMemoria), .enderecoIgualSequencia(enderecoIgualSequencia),
        .fimS(fimS), .timeout(timeout),
        .zeraE(zeraE2), .contaE(contaE2), .zeraS(zeraS2), .contaS(contaS2),
        .zeraR(zeraR2), .registraR(registraR2), .estado_espera(espera2),
        .pronto(pronto2), .acertou(acertou2), .errou(errou2), .fim_timeout(fim_to2),
        .db_estado(db2)
    );

    assign o1 = {zeraE1, contaE1, zeraS1, contaS1, zeraR1, registraR1, espera1, pronto1, acertou1, errou1, fim_to1};
    assign o2 = {zeraE2, contaE2, zeraS2, contaS2, zeraR2, registraR2, espera2, pronto2, acertou2, errou2, fim_to2};

    // Game phases of the model, named by what the game is doing
    localparam int P_IDLE = 0, P_SETUP = 1, P_ROUND = 2, P_WAIT = 3, P_LATCH = 4,
                   P_JUDGE = 5, P_NEXTPLAY = 6, P_NEXTROUND = 7,
                   P_WON = 10, P_TIMEDOUT = 13, P_LOST = 14;

    // Strobes each phase must raise, in order
    // {zeraE, contaE, zeraS, contaS, zeraR, registraR, espera, pronto, acertou, errou, fim_timeout}
    function automatic logic [10:0] phase_outputs(input int p);
        case (p)
            P_SETUP:     return 11'b1_0_1_0_1_0_0_0_0_0_0;
            P_ROUND:     return 11'b1_0_0_0_0_0_0_0_0_0_0;
            P_WAIT:      return 11'b0_0_0_0_0_0_1_0_0_0_0;
            P_LATCH:     return 11'b0_0_0_0_0_1_0_0_0_0_0;
            P_NEXTPLAY:  return 11'b0_1_0_0_0_0_0_0_0_0_0;
            P_NEXTROUND: return 11'b0_0_0_1_0_0_0_0_0_0_0;
            P_WON:       return 11'b0_0_0_0_0_0_0_1_1_0_0;
            P_LOST:      return 11'b0_0_0_0_0_0_0_1_0_1_0;
            P_TIMEDOUT:  return 11'b0_0_0_0_0_0_0_1_0_0_1;
            default:     return 11'b0;
        endcase
    endfunction

    function automatic int phase_after(input int p, input bit honour_to);
        if (p == P_IDLE || p == P_WON || p == P_LOST || p == P_TIMEDOUT)
            return iniciar ? P_SETUP : p;
        if (p == P_SETUP || p == P_NEXTROUND) return P_ROUND;
        if (p == P_ROUND || p == P_NEXTPLAY)  return P_WAIT;
        if (p == P_WAIT) begin
            if (honour_to && timeout) return P_TIMEDOUT;
            return jogada ? P_LATCH : P_WAIT;
        end
        if (p == P_LATCH) return P_JUDGE;
        if (!jogadaIgualMemoria)     return P_LOST;
        if (!enderecoIgualSequencia) return P_NEXTPLAY;
        return fimS ? P_WON : P_NEXTROUND;
    endfunction

    int m1 = P_IDLE;
    int m2 = P_IDLE;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m1 <= P_IDLE;
            m2 <= P_IDLE;
        end else begin
            m1 <= phase_after(m1, 1'b1);
            m2 <= phase_after(m2, 1'b0);
        end
    end

    always @(posedge clock) begin
        if (zeraE1)       dp_addr <= 4'd0;
        else if (contaE1) dp_addr <= dp_addr + 4'd1;
        if (zeraS1)       dp_round <= 4'd0;
        else if (contaS1) dp_round <= dp_round + 4'd1;
    end

    // per-cycle comparison against the model
    always @(negedge clock) begin
        checks++;
        if (o1 !== phase_outputs(m1) || db1 !== 4'(m1)) begin
            errors++;
            $display("FAIL model_dut t=%0t: got outs=%b db=%h, want outs=%b db=%h",
                     $time, o1, db1, phase_outputs(m1), 4'(m1));
        end
        checks++;
        if (o2 !== phase_outputs(m2) || db2 !== 4'(m2)) begin
            errors++;
            $display("FAIL model_dut_nt t=%0t: got outs=%b db=%h, want outs=%b db=%h",
                     $time, o2, db2, phase_outputs(m2), 4'(m2));
        end
    end

    int reg_pulses = 0;
    always @(negedge clock) if (win_mode && registraR1) reg_pulses++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end else begin
            $display("check %s: %0h ok", name, act);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic start_game();
        iniciar = 1'b1; tick();
        chk("start_db1", db1, 32'h1);
        chk("start_clears", {zeraE1, zeraS1, zeraR1}, 32'h7);
        iniciar = 1'b0; tick();
        chk("start_db2", db1, 32'h2);
        tick();
        chk("start_db3", db1, 32'h3);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_db", db1, 32'h0);
        chk("reset_outs", o1, 32'h0);
        reset = 1'b1; tick();
        chk("idle_no_start", db1, 32'h0);
        start_game();

        // asynchronous reset from espera_jogada
        #2 reset = 1'b0;
        #1;
        chk("async_db", db1, 32'h0);
        chk("async_outs", o1, 32'h0);
        tick(); reset = 1'b1; tick();
        start_game();

        // round 0 correct
        s_eq = 1'b1; s_eis = 1'b1; s_fim = 1'b0;
        jogada = 1'b1; tick(); jogada = 1'b0;
        chk("r0_latch", {db1, registraR1}, 32'h9);
        tick(); chk("r0_judge", {db1, registraR1}, 32'ha);
        tick(); chk("r0_nextround", {db1, contaS1}, 32'hf);
        tick(); chk("r0_round", {db1, contaS1}, 32'h4);
        tick(); chk("r0_wait", db1, 32'h3);

        // mid-round correct
        s_eis = 1'b0;
        jogada = 1'b1; tick(); jogada = 1'b0;
        tick(); chk("mid_judge", db1, 32'h5);
        tick(); chk("mid_nextplay", {db1, contaE1}, 32'hd);
        tick(); chk("mid_wait", {db1, contaE1}, 32'h6);

        // wrong play, flags held until iniciar
        s_eq = 1'b0;
        jogada = 1'b1; tick(); jogada = 1'b0;
        tick(); tick();
        chk("lost_db", db1, 32'he);
        repeat (3) tick();
        chk("lost_hold", {pronto1, errou1, acertou1, fim_to1}, 32'hc);
        start_game();

        // timeout and play together
        timeout = 1'b1; jogada = 1'b1; tick();
        timeout = 1'b0; jogada = 1'b0;
        chk("to_db", {db1, fim_to1}, 32'h1b);
        chk("to_ignored_db", db2, 32'h4);
        tick(); reset = 1'b0; tick(); reset = 1'b1; tick();

        // full game through a modelled datapath
        start_game();
        win_mode = 1'b1;
        for (int c = 0; c < 3000 && !pronto1; c++) begin
            jogada = (db1 == 4'h3);
            tick();
        end
        jogada = 1'b0;
        tick();
        chk("win_pronto", pronto1, 32'h1);
        chk("win_db", db1, 32'ha);
        chk("win_acertou", acertou1, 32'h1);
        chk("win_plays", reg_pulses, 32'd136);
        win_mode = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
